// File: rtl/blur_window_feeder.sv
`default_nettype none
// ============================================================================
// Module   : blur_window_feeder
// Purpose  : Producer side of the blur_controller window interface. Walks the
//            anchor over the frame strip-major (rows inside a 16-column strip),
//            fetches each 20-pixel window from word-wide frame memory and
//            stages it while the controller processes the current window.
// Ports    : clk, n_rst (async, active-low)
//            start / busy / frame_done          frame control
//            mem_req / mem_addr / mem_ack / mem_rdata   word read port
//            anchor_moving / anchor_x / anchor_y / blur_in   window output
//            blur_final                          controller finished window
// Revision : 1.0  initial release
// ============================================================================
module blur_window_feeder #(
   parameter int IMG_W  = 640,
   parameter int IMG_H  = 480,
   parameter int ADDR_W = 20,
   parameter int BASE   = 0
) (
   input  logic              clk,
   input  logic              n_rst,
   input  logic              start,
   output logic              busy,
   output logic              frame_done,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_ack,
   input  logic [31:0]       mem_rdata,
   output logic              anchor_moving,
   output logic [31:0]       anchor_x,
   output logic [31:0]       anchor_y,
   output logic [19:0][7:0]  blur_in,
   input  logic              blur_final
);

   localparam int          c_WPR    = IMG_W / 4;
   localparam logic [31:0] c_LAST_Y = 32'(IMG_W - 16);
   localparam logic [31:0] c_LAST_X = 32'(IMG_H - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_FETCH  = 2'd1,
      S_STAGED = 2'd2,
      S_DRAIN  = 2'd3
   } state_t;

   state_t           r_state;
   logic [31:0]      r_fx;          // row of the window being fetched/staged
   logic [31:0]      r_fy;          // strip start column of that window
   logic [2:0]       r_k;           // word slot 0..5 = word anchor_y/4-1+k
   logic [19:0][7:0] r_stage;
   logic             r_win_busy;

   logic [ADDR_W-1:0] w_addr;
   logic [2:0]        w_k_last;
   logic [2:0]        w_k_first;
   logic [31:0]       w_nx;
   logic [31:0]       w_ny;
   logic              w_last_win;
   logic [19:0][7:0]  w_stage_nxt;
   logic [19:0][7:0]  w_win;

   // Right strip has no word beyond the frame edge, so the fetch stops at slot 4.
   assign w_k_last   = (r_fy == c_LAST_Y) ? 3'd4 : 3'd5;
   assign w_last_win = (r_fx == c_LAST_X) && (r_fy == c_LAST_Y);
   assign w_nx       = (r_fx == c_LAST_X) ? 32'd0 : r_fx + 32'd1;
   assign w_ny       = (r_fx == c_LAST_X) ? r_fy + 32'd16 : r_fy;
   // Left strip skips slot 0, which would lie left of column 0.
   assign w_k_first  = (w_ny == 32'd0) ? 3'd1 : 3'd0;

   assign w_addr = ADDR_W'(BASE) + ADDR_W'(r_fx * c_WPR) + ADDR_W'(r_fy >> 2)
                 + ADDR_W'(r_k) - ADDR_W'(1);

   // Gated so the address bus reads 0 whenever no request is pending.
   assign mem_addr = mem_req ? w_addr : '0;

   // Slot k carries columns anchor_y-4+4k .. +3; staging index i holds column
   // anchor_y-2+i, so byte (i+2)%4 of slot (i+2)/4 lands in entry i. The two
   // lowest bytes of slot 0 and the two highest of slot 5 fall outside.
   always_comb begin
      w_stage_nxt = r_stage;
      for (int i = 0; i < 20; i++) begin
         if (r_k == 3'((i + 2) / 4))
            w_stage_nxt[i] = mem_rdata[((i + 2) % 4) * 8 +: 8];
      end
   end

   // Edge strips never fetched their outer columns; replicate the frame edge.
   always_comb begin
      w_win = r_stage;
      if (r_fy == 32'd0) begin
         w_win[0] = r_stage[2];
         w_win[1] = r_stage[2];
      end
      if (r_fy == c_LAST_Y) begin
         w_win[18] = r_stage[17];
         w_win[19] = r_stage[17];
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_state       <= S_IDLE;
         r_fx          <= '0;
         r_fy          <= '0;
         r_k           <= '0;
         r_stage       <= '0;
         r_win_busy    <= 1'b0;
         busy          <= 1'b0;
         frame_done    <= 1'b0;
         mem_req       <= 1'b0;
         anchor_moving <= 1'b0;
         anchor_x      <= '0;
         anchor_y      <= '0;
         blur_in       <= '0;
      end else begin
         anchor_moving <= 1'b0;
         frame_done    <= 1'b0;
         // A hand-over in the same cycle re-sets win_busy below.
         if (blur_final)
            r_win_busy <= 1'b0;

         case (r_state)
            S_IDLE: begin
               if (start) begin
                  busy    <= 1'b1;
                  r_fx    <= '0;
                  r_fy    <= '0;
                  r_k     <= 3'd1;
                  mem_req <= 1'b1;
                  r_state <= S_FETCH;
               end
            end

            S_FETCH: begin
               if (mem_ack) begin
                  r_stage <= w_stage_nxt;
                  if (r_k == w_k_last) begin
                     mem_req <= 1'b0;
                     r_state <= S_STAGED;
                  end else begin
                     r_k <= r_k + 3'd1;
                  end
               end
            end

            S_STAGED: begin
               if (!r_win_busy || blur_final) begin
                  blur_in       <= w_win;
                  anchor_x      <= r_fx;
                  anchor_y      <= r_fy;
                  anchor_moving <= 1'b1;
                  r_win_busy    <= 1'b1;
                  if (w_last_win) begin
                     r_state <= S_DRAIN;
                  end else begin
                     r_fx    <= w_nx;
                     r_fy    <= w_ny;
                     r_k     <= w_k_first;
                     mem_req <= 1'b1;
                     r_state <= S_FETCH;
                  end
               end
            end

            S_DRAIN: begin
               if (blur_final) begin
                  frame_done <= 1'b1;
                  busy       <= 1'b0;
                  r_state    <= S_IDLE;
               end
            end

            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_blur_window_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_blur_window_feeder
// Purpose  : Self-checking bench for blur_window_feeder on a 32x2 frame with
//            pixel = (col + 3*row) & 0xFF. A memory model answers reads with
//            optional wait states; a controller model consumes windows and
//            checks them against a scoreboard of expected windows.
// Revision : 1.0  initial release
// ============================================================================
module tb_blur_window_feeder;

   localparam int IMG_W  = 32;
   localparam int IMG_H  = 2;
   localparam int ADDR_W = 20;
   localparam int BASE   = 0;
   localparam int WPR    = IMG_W / 4;

   typedef struct {
      int               x;
      int               y;
      logic [19:0][7:0] pix;
   } win_t;

   logic              clk = 1'b0;
   logic              n_rst = 1'b0;
   logic              start = 1'b0;
   logic              busy;
   logic              frame_done;
   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_ack;
   logic [31:0]       mem_rdata = '0;
   logic              anchor_moving;
   logic [31:0]       anchor_x;
   logic [31:0]       anchor_y;
   logic [19:0][7:0]  blur_in;
   logic              blur_final;

   logic ack_model = 1'b0, ack_tog = 1'b0;
   logic bf_model  = 1'b0, bf_tog  = 1'b0;
   assign mem_ack    = ack_model | ack_tog;
   assign blur_final = bf_model | bf_tog;

   int checks = 0;
   int errors = 0;

   win_t sb[$];

   always #5 clk = ~clk;

   blur_window_feeder #(
      .IMG_W (IMG_W),
      .IMG_H (IMG_H),
      .ADDR_W(ADDR_W),
      .BASE  (BASE)
   ) dut (
      .clk          (clk),
      .n_rst        (n_rst),
      .start        (start),
      .busy         (busy),
      .frame_done   (frame_done),
      .mem_req      (mem_req),
      .mem_addr     (mem_addr),
      .mem_ack      (mem_ack),
      .mem_rdata    (mem_rdata),
      .anchor_moving(anchor_moving),
      .anchor_x     (anchor_x),
      .anchor_y     (anchor_y),
      .blur_in      (blur_in),
      .blur_final   (blur_final)
   );

   function automatic logic [19:0][7:0] exp_win(input int x, input int y);
      logic [19:0][7:0] w;
      int c;
      for (int i = 0; i < 20; i++) begin
         c = y - 2 + i;
         if (c < 0) c = 0;
         if (c > IMG_W - 1) c = IMG_W - 1;
         w[i] = 8'((c + 3 * x) & 255);
      end
      return w;
   endfunction

   function automatic logic [31:0] pix_word(input logic [ADDR_W-1:0] a);
      logic [31:0] d;
      int off, row, wc;
      off = int'(a) - BASE;
      row = off / WPR;
      wc  = off % WPR;
      for (int j = 0; j < 4; j++)
         d[8*j +: 8] = 8'((4 * wc + j + 3 * row) & 255);
      return d;
   endfunction

   // ---------------- memory model ----------------
   bit                rnd_wait = 1'b0;
   bit                pending  = 1'b0;
   int                mem_wait = 0;
   logic [ADDR_W-1:0] hold_addr = '0;

   always @(negedge clk) begin
      ack_model = 1'b0;
      if (!n_rst) begin
         pending = 1'b0;
      end else begin
         if (pending) begin
            checks++;
            assert (mem_req === 1'b1 && mem_addr === hold_addr) else begin
               errors++;
               $error("FAIL addr_stable req=%0b addr=%0h exp req=1 addr=%0h", mem_req, mem_addr, hold_addr);
            end
         end else if (mem_req) begin
            pending   = 1'b1;
            hold_addr = mem_addr;
            mem_wait  = rnd_wait ? int'($urandom_range(5, 0)) : 0;
         end
         if (pending) begin
            if (mem_wait == 0) begin
               ack_model = 1'b1;
               mem_rdata = pix_word(mem_addr);
               pending   = 1'b0;
            end else begin
               mem_wait--;
            end
         end
      end
   end

   // ---------------- controller model / scoreboard ----------------
   int   cdelay = 9;
   int   exp_gap = 0;
   int   ccnt = 0;
   int   gap_cnt = 0;
   bit   cbusy = 1'b0;
   bit   tracking = 1'b0;
   int   amov_cnt = 0;
   int   fdone_cnt = 0;
   win_t cur;
   win_t e;

   always @(negedge clk) begin
      bf_model = 1'b0;
      if (!n_rst) begin
         cbusy    = 1'b0;
         tracking = 1'b0;
      end else begin
         if (tracking) gap_cnt++;
         if (frame_done) fdone_cnt++;
         if (anchor_moving) begin
            amov_cnt++;
            checks++;
            assert (!cbusy) else begin
               errors++;
               $error("FAIL handover_before_final cbusy=%0b exp 0", cbusy);
            end
            if (tracking && exp_gap > 0) begin
               checks++;
               assert (gap_cnt == exp_gap) else begin
                  errors++;
                  $error("FAIL final_to_move_gap got %0d exp %0d", gap_cnt, exp_gap);
               end
            end
            tracking = 1'b0;
            checks++;
            assert (sb.size() > 0) else begin
               errors++;
               $error("FAIL extra_window x=%0d y=%0d exp none", anchor_x, anchor_y);
            end
            if (sb.size() > 0) begin
               e = sb.pop_front();
               checks++;
               assert (anchor_x === 32'(e.x) && anchor_y === 32'(e.y)) else begin
                  errors++;
                  $error("FAIL window_pos got (%0d,%0d) exp (%0d,%0d)", anchor_x, anchor_y, e.x, e.y);
               end
               checks++;
               assert (blur_in === e.pix) else begin
                  errors++;
                  $error("FAIL window_pix (%0d,%0d) got %h exp %h", e.x, e.y, blur_in, e.pix);
               end
               cur = e;
            end
            cbusy = 1'b1;
            ccnt  = cdelay;
         end else if (cbusy) begin
            checks++;
            assert (anchor_x === 32'(cur.x) && anchor_y === 32'(cur.y) && blur_in === cur.pix) else begin
               errors++;
               $error("FAIL window_stable got (%0d,%0d) %h exp (%0d,%0d) %h", anchor_x, anchor_y, blur_in, cur.x, cur.y, cur.pix);
            end
            if (ccnt == 0) begin
               bf_model = 1'b1;
               cbusy    = 1'b0;
               tracking = 1'b1;
               gap_cnt  = 0;
            end else begin
               ccnt--;
            end
         end
      end
   end

   // ---------------- frame runner ----------------
   task automatic run_frame(input int d, input bit rnd, input int gap, input bit lat_chk, input bit dup);
      int   n;
      bit   seen;
      win_t w;
      cdelay    = d;
      rnd_wait  = rnd;
      exp_gap   = gap;
      amov_cnt  = 0;
      fdone_cnt = 0;
      tracking  = 1'b0;
      for (int y = 0; y < IMG_W; y += 16) begin
         for (int x = 0; x < IMG_H; x++) begin
            w.x   = x;
            w.y   = y;
            w.pix = exp_win(x, y);
            sb.push_back(w);
         end
      end
      @(posedge clk); #2;
      start = 1'b1;
      n = 0;
      seen = 1'b0;
      while (!seen && n < 2000) begin
         @(posedge clk); #1;
         n++;
         if (n == 1) start = 1'b0;
         if (anchor_moving) seen = 1'b1;
      end
      checks++;
      assert (seen) else begin
         errors++;
         $error("FAIL first_window_timeout cycles=%0d exp <2000", n);
      end
      if (lat_chk) begin
         checks++;
         assert (n == 7) else begin
            errors++;
            $error("FAIL start_latency got %0d exp 7", n);
         end
      end
      seen = 1'b0;
      n = 0;
      while (!seen && n < 5000) begin
         @(posedge clk); #1;
         n++;
         if (dup && n == 5) start = 1'b1;
         if (n == 6) start = 1'b0;
         if (frame_done) seen = 1'b1;
      end
      checks++;
      assert (seen) else begin
         errors++;
         $error("FAIL frame_done_timeout cycles=%0d exp <5000", n);
      end
      repeat (30) @(posedge clk);
      #1;
      checks++;
      assert (amov_cnt == 4) else begin
         errors++;
         $error("FAIL move_pulses got %0d exp 4", amov_cnt);
      end
      checks++;
      assert (fdone_cnt == 1) else begin
         errors++;
         $error("FAIL frame_done_pulses got %0d exp 1", fdone_cnt);
      end
      checks++;
      assert (sb.size() == 0) else begin
         errors++;
         $error("FAIL windows_missing got %0d left exp 0", sb.size());
      end
      checks++;
      assert (busy === 1'b0) else begin
         errors++;
         $error("FAIL busy_after_frame got %0b exp 0", busy);
      end
      sb.delete();
   endtask

   initial begin
      // Reset held with inputs toggling: every output must stay 0.
      for (int c = 0; c < 8; c++) begin
         @(posedge clk); #2;
         start   = c[0];
         ack_tog = c[1];
         bf_tog  = ~c[0];
         #1;
         checks++;
         assert ({busy, frame_done, mem_req, anchor_moving} === 4'b0 && mem_addr === '0 &&
                 anchor_x === 32'd0 && anchor_y === 32'd0 && blur_in === '0) else begin
            errors++;
            $error("FAIL reset_outputs busy=%0b fd=%0b req=%0b mv=%0b addr=%0h exp all 0", busy, frame_done, mem_req, anchor_moving, mem_addr);
         end
      end
      @(posedge clk); #2;
      start   = 1'b0;
      ack_tog = 1'b0;
      bf_tog  = 1'b0;
      n_rst   = 1'b1;
      repeat (2) @(posedge clk);

      // Zero-wait memory, normal consumer, latency check.
      run_frame(9, 1'b0, 1, 1'b1, 1'b0);
      // Random wait states plus a start pulse while busy.
      run_frame(9, 1'b1, 0, 1'b0, 1'b1);
      // Slow consumer: FSM parks in STAGED, next window the cycle after blur_final.
      run_frame(199, 1'b0, 1, 1'b1, 1'b0);
      // blur_final lands with the last ack: hand-over one cycle later.
      run_frame(3, 1'b0, 2, 1'b1, 1'b0);

      // Abort mid-FETCH with reset.
      fdone_cnt = 0;
      @(posedge clk); #2;
      start = 1'b1;
      @(posedge clk); #2;
      start = 1'b0;
      @(posedge clk); #2;
      checks++;
      assert (mem_req === 1'b1 && busy === 1'b1) else begin
         errors++;
         $error("FAIL fetch_active req=%0b busy=%0b exp 1 1", mem_req, busy);
      end
      n_rst = 1'b0;
      #1;
      checks++;
      assert ({busy, frame_done, mem_req, anchor_moving} === 4'b0 && mem_addr === '0) else begin
         errors++;
         $error("FAIL abort_outputs busy=%0b fd=%0b req=%0b mv=%0b addr=%0h exp all 0", busy, frame_done, mem_req, anchor_moving, mem_addr);
      end
      repeat (3) @(posedge clk);
      #2;
      n_rst = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      checks++;
      assert (fdone_cnt == 0 && busy === 1'b0 && mem_req === 1'b0) else begin
         errors++;
         $error("FAIL abort_quiet fd_pulses=%0d busy=%0b req=%0b exp 0 0 0", fdone_cnt, busy, mem_req);
      end
      // Fresh frame after the abort starts again from row 0.
      run_frame(9, 1'b0, 1, 1'b1, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
